// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - shared FSM states, register map and command-byte layout
package adxl345_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_MB_BIT   = 6;
    localparam int CMD_ADDR_MSB = 5;

    // DEVID and the live sample registers are read-only from the bus
    function automatic logic is_writable(input logic [5:0] addr);
        return !((addr == ADDR_DEVID) || ((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1)));
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser with rise/fall strobes
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/adxl345_spi_slave.sv
// rtl/adxl345_spi_slave.sv - ADXL345-style SPI mode 3 register slave with sample buffering
module adxl345_spi_slave
    import adxl345_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic        reg_wr,
    output logic [5:0]  reg_wr_addr,
    output logic [7:0]  reg_wr_data,
    output logic [7:0]  data_format,
    output logic        busy
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (.clk(clk), .rst(rst), .i_async(spi_clk),
        .o_sync(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (.clk(clk), .rst(rst), .i_async(CS),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_async(MOSI),
        .o_sync(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused));

    state_t      r_state, w_state_next;
    logic [1:0]  r_flush_cnt;
    logic        r_cs_armed;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift_in;
    logic [7:0]  r_tx_shift;
    logic        r_miso;
    logic        r_mb;
    logic [5:0]  r_addr;
    logic        r_reg_wr;
    logic [5:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_regs [64];
    logic [47:0] r_shadow;
    logic        r_pending;

    logic [7:0]  w_rx_byte;
    logic [47:0] w_load;
    logic        w_start;

    assign w_rx_byte = {r_shift_in[6:0], w_mosi};
    assign w_load    = sample_valid ? {sample_z, sample_y, sample_x} : r_shadow;
    // After reset the CS pipeline still holds its idle value; only a fall seen
    // after a real high level may start a transaction.
    assign w_start   = w_cs_fall & r_cs_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= 2'd0;
            r_cs_armed  <= 1'b0;
        end else begin
            if (r_flush_cnt != 2'd2) r_flush_cnt <= r_flush_cnt + 2'd1;
            if ((r_flush_cnt == 2'd2) && w_cs_sync) r_cs_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_next = ST_CMD;
            ST_CMD: if (w_sclk_rise && (r_bit_cnt == 3'd7))
                w_state_next = w_rx_byte[CMD_RW_BIT] ? ST_RDATA : ST_WDATA;
            default: ;
        endcase
        if (w_cs_rise) w_state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_shift_in <= 8'h00;
            r_tx_shift <= 8'h00;
            r_miso     <= 1'b0;
            r_mb       <= 1'b0;
            r_addr     <= 6'd0;
            r_reg_wr   <= 1'b0;
            r_wr_addr  <= 6'd0;
            r_wr_data  <= 8'h00;
            r_shadow   <= 48'd0;
            r_pending  <= 1'b0;
            for (int i = 0; i < 64; i++) r_regs[i] <= 8'h00;
            r_regs[ADDR_DEVID]   <= DEVID;
            r_regs[ADDR_BW_RATE] <= BW_RATE_RST;
        end else begin
            r_reg_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= 3'd0;
                    r_miso    <= 1'b0;
                end
                ST_CMD: if (w_sclk_rise) begin
                    r_shift_in <= w_rx_byte;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_mb   <= w_rx_byte[CMD_MB_BIT];
                        r_addr <= w_rx_byte[CMD_ADDR_MSB:0];
                    end
                end
                ST_WDATA: if (w_sclk_rise) begin
                    r_shift_in <= w_rx_byte;
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (is_writable(r_addr)) begin
                            r_regs[r_addr] <= w_rx_byte;
                            r_reg_wr       <= 1'b1;
                            r_wr_addr      <= r_addr;
                            r_wr_data      <= w_rx_byte;
                        end
                        if (r_mb) r_addr <= r_addr + 6'd1;
                    end
                end
                default: begin
                    // bit counter is zero exactly on the first fall of each byte
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == 3'd0) begin
                            r_miso     <= r_regs[r_addr][7];
                            r_tx_shift <= {r_regs[r_addr][6:0], 1'b0};
                        end else begin
                            r_miso     <= r_tx_shift[7];
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end
                    end
                    if (w_sclk_rise) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if ((r_bit_cnt == 3'd7) && r_mb) r_addr <= r_addr + 6'd1;
                    end
                end
            endcase

            // Samples arriving mid-transaction wait in the shadow so a burst read stays coherent
            if (r_state == ST_IDLE) begin
                if (sample_valid || r_pending)
                    for (int k = 0; k < 6; k++) r_regs[ADDR_DATAX0 + 6'(k)] <= w_load[8*k +: 8];
                r_pending <= 1'b0;
            end else if (sample_valid) begin
                r_shadow  <= {sample_z, sample_y, sample_x};
                r_pending <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign MISO_oe     = ~w_cs_sync;
    assign MISO        = (MISO_oe && (r_state == ST_RDATA)) ? r_miso : 1'b0;
    assign reg_wr      = r_reg_wr;
    assign reg_wr_addr = r_wr_addr;
    assign reg_wr_data = r_wr_data;
    assign data_format = r_regs[ADDR_DATA_FORMAT];

endmodule

// File: tb/tb_adxl345_spi_slave.sv
// tb/tb_adxl345_spi_slave.sv - directed self-checking bench for adxl345_spi_slave
module tb_adxl345_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b1;
    logic        CS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO, MISO_oe;
    logic [15:0] sample_x = 16'h0, sample_y = 16'h0, sample_z = 16'h0;
    logic        sample_valid = 1'b0;
    logic        reg_wr;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic [7:0]  data_format;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [5:0] last_addr = 6'd0;
    logic [7:0] last_data = 8'h00;

    adxl345_spi_slave dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .CS(CS), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe),
        .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
        .sample_valid(sample_valid),
        .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .data_format(data_format), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            last_addr = reg_wr_addr;
            last_data = reg_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        CS = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_high();
        CS = 1'b1;
        wait_clk(8);
    endtask

    // mode 3: drive on the falling half, sample MISO just before the rising edge
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit pulse, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_clk = 1'b0;
            MOSI    = tx[7-i];
            if (pulse && i == 3) begin
                sample_valid = 1'b1;
                wait_clk(1);
                sample_valid = 1'b0;
                wait_clk(7);
            end else begin
                wait_clk(8);
            end
            rx = {rx[6:0], MISO};
            spi_clk = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic read_burst(input logic [7:0] cmd, input int n, input int pulse_byte,
                              output logic [7:0] got [6]);
        logic [7:0] rx;
        cs_low();
        xfer(cmd, 8, 1'b0, rx);
        for (int b = 0; b < n; b++) begin
            xfer(8'h00, 8, (b == pulse_byte), rx);
            got[b] = rx;
        end
        cs_high();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] got [6];
        logic [7:0] exp_a [6];
        logic [7:0] exp_b [6];
        int wr_before;

        exp_a[0] = 8'h34; exp_a[1] = 8'h12; exp_a[2] = 8'hCD;
        exp_a[3] = 8'hAB; exp_a[4] = 8'h0F; exp_a[5] = 8'h0F;
        exp_b[0] = 8'h11; exp_b[1] = 8'h11; exp_b[2] = 8'h22;
        exp_b[3] = 8'h22; exp_b[4] = 8'h33; exp_b[5] = 8'h33;

        wait_clk(4);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso_oe", 32'(MISO_oe), 32'd0);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_data_format", 32'(data_format), 32'h00);
        rst = 1'b0;
        wait_clk(6);

        // single-byte read of DEVID
        cs_low();
        check("busy_after_cs", 32'(busy), 32'd1);
        check("miso_oe_cs_low", 32'(MISO_oe), 32'd1);
        xfer(8'h80, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        cs_high();
        check("devid", 32'(rx), 32'hE5);
        check("busy_after_cs_high", 32'(busy), 32'd0);

        // write DATA_FORMAT
        wr_before = wr_cnt;
        cs_low();
        xfer(8'h31, 8, 1'b0, rx);
        xfer(8'h0B, 8, 1'b0, rx);
        cs_high();
        check("wr_cnt_0x31", 32'(wr_cnt - wr_before), 32'd1);
        check("wr_addr_0x31", 32'(last_addr), 32'h31);
        check("wr_data_0x31", 32'(last_data), 32'h0B);
        check("data_format", 32'(data_format), 32'h0B);

        // sample in IDLE, then 6-byte burst
        sample_x = 16'h1234; sample_y = 16'hABCD; sample_z = 16'h0F0F;
        sample_valid = 1'b1; wait_clk(1); sample_valid = 1'b0;
        wait_clk(3);
        read_burst(8'hF2, 6, -1, got);
        for (int i = 0; i < 6; i++) check($sformatf("burst1_b%0d", i), 32'(got[i]), 32'(exp_a[i]));

        // new sample during byte 2 must not disturb the burst
        sample_x = 16'h1111; sample_y = 16'h2222; sample_z = 16'h3333;
        read_burst(8'hF2, 6, 1, got);
        for (int i = 0; i < 6; i++) check($sformatf("burst_old_b%0d", i), 32'(got[i]), 32'(exp_a[i]));
        read_burst(8'hF2, 6, -1, got);
        for (int i = 0; i < 6; i++) check($sformatf("burst_new_b%0d", i), 32'(got[i]), 32'(exp_b[i]));

        // write to a sample register is dropped; MB=0 read holds the address
        wr_before = wr_cnt;
        cs_low();
        xfer(8'h32, 8, 1'b0, rx);
        xfer(8'h55, 8, 1'b0, rx);
        cs_high();
        check("wr_0x32_dropped", 32'(wr_cnt - wr_before), 32'd0);
        read_burst(8'hB2, 2, -1, got);
        check("reread_0x32_b0", 32'(got[0]), 32'h11);
        check("reread_0x32_b1", 32'(got[1]), 32'h11);

        // write 0x3F, then MB read wraps to 0x00
        wr_before = wr_cnt;
        cs_low();
        xfer(8'h3F, 8, 1'b0, rx);
        xfer(8'hA7, 8, 1'b0, rx);
        cs_high();
        check("wr_cnt_0x3f", 32'(wr_cnt - wr_before), 32'd1);
        check("wr_addr_0x3f", 32'(last_addr), 32'h3F);
        read_burst(8'hFF, 2, -1, got);
        check("wrap_b0", 32'(got[0]), 32'hA7);
        check("wrap_b1", 32'(got[1]), 32'hE5);

        // aborted command after 4 bits
        wr_before = wr_cnt;
        cs_low();
        xfer(8'h3F, 4, 1'b0, rx);
        cs_high();
        check("abort_busy", 32'(busy), 32'd0);
        read_burst(8'hAC, 1, -1, got);
        check("bw_rate_after_abort", 32'(got[0]), 32'h0A);
        check("abort_no_write", 32'(wr_cnt - wr_before), 32'd0);

        // reset while CS is held low
        cs_low();
        xfer(8'h80, 8, 1'b0, rx);
        rst = 1'b1; wait_clk(3); rst = 1'b0;
        wait_clk(4);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_data_format", 32'(data_format), 32'h00);
        xfer(8'h80, 8, 1'b0, rx);
        xfer(8'h00, 8, 1'b0, rx);
        check("rst_mid_no_response", 32'(rx), 32'h00);
        check("rst_mid_still_idle", 32'(busy), 32'd0);
        cs_high();
        read_burst(8'h80, 1, -1, got);
        check("devid_after_cycle", 32'(got[0]), 32'hE5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adxl345_spi_slave.md
ADXL345_SPI_SLAVE -- requirements
Module: adxl345_spi_slave

Interface
REQ-001 SHALL have parameter DEVID, default 8'hE5, value returned at register 0x00.
REQ-002 SHALL have parameter BW_RATE_RST, default 8'h0A, reset value of register 0x2C.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spi_clk  input  1  SPI clock from master, asynchronous, idles high.
REQ-006 SHALL have port CS  input  1  active-low chip select, asynchronous.
REQ-007 SHALL have port MOSI  input  1  serial data from master, asynchronous.
REQ-008 SHALL have port MISO  output  1  serial data to master.
REQ-009 SHALL have port MISO_oe  output  1  high when MISO is driven.
REQ-010 SHALL have ports sample_x, sample_y, sample_z  input  16 each  new axis samples.
REQ-011 SHALL have port sample_valid  input  1  one-cycle strobe qualifying sample_x/y/z.
REQ-012 SHALL have ports reg_wr, reg_wr_addr, reg_wr_data  output  1/6/8  one-cycle pulse plus address and data per completed register write.
REQ-013 SHALL have port data_format  output  8  current contents of register 0x31.
REQ-014 SHALL have port busy  output  1  high while a transaction is active.

Function
REQ-015 SHALL synchronise spi_clk, CS and MOSI through 2 flops, then detect edges with 1 more flop; the spi_clk period SHALL be at least 8 clk cycles.
REQ-016 SHALL implement SPI mode 3: MOSI sampled on synchronised spi_clk rising edge; MISO updated on falling edge; MSB first.
REQ-017 SHALL use FSM states IDLE, CMD, WDATA, RDATA.
REQ-018 IDLE->CMD when synchronised CS falls; bit counter cleared; busy=1.
REQ-019 CMD: 8 rising edges capture the command byte: bit7 R/W (1=read), bit6 MB (multi-byte), bits5:0 start address.
REQ-020 After the 8th bit: R/W=1 -> RDATA, R/W=0 -> WDATA.
REQ-021 RDATA: shift register loads reg[addr] and drives its bit7 on the first falling edge after the 8th command bit; each later falling edge shifts the next bit.
REQ-022 WDATA: after 8 rising edges, reg[addr] is written and reg_wr pulses for 1 cycle with reg_wr_addr/reg_wr_data.
REQ-023 After each completed data byte, address SHALL increment if MB=1 (0x3F wraps to 0x00) and hold if MB=0; the transfer continues.
REQ-024 Writes to 0x00 and 0x32-0x37 SHALL be discarded with no reg_wr pulse; all other addresses are writable.
REQ-025 Synchronised CS rising in any state -> IDLE next cycle; a partial byte is discarded; busy=0.
REQ-026 MISO_oe = synchronised CS low; MISO=0 whenever MISO_oe=0 or in CMD/WDATA.
REQ-027 Registers 0x32-0x37 hold X0,X1,Y0,Y1,Z0,Z1 (low byte at even address).
REQ-028 sample_valid in IDLE SHALL load 0x32-0x37 on the next cycle.
REQ-029 sample_valid while busy SHALL store the sample in a shadow buffer and set pending, so a multi-byte read never mixes samples.
REQ-030 The pending sample SHALL be copied in the IDLE cycle after CS rises; a newer sample_valid overwrites the shadow (last wins).
REQ-031 If sample_valid coincides with the pending copy, the new sample SHALL win.

Reset
REQ-032 On rst: FSM=IDLE; registers=0 except 0x00=DEVID and 0x2C=BW_RATE_RST; pending=0; MISO=0; MISO_oe=0; reg_wr=0; busy=0; data_format=0; synchronisers set to idle (spi_clk=1, CS=1).
REQ-033 rst mid-transaction SHALL abort it; the block SHALL wait for a fresh CS fall and SHALL NOT treat the still-low CS as a new start.

Structure
REQ-034 A shared package adxl345_pkg SHALL hold the FSM state enum, register addresses (DEVID 0x00, BW_RATE 0x2C, POWER_CTL 0x2D, DATA_FORMAT 0x31, DATAX0 0x32) and command bit positions.
REQ-035 A single sub-module spi_sync_edge SHALL provide the 2-flop synchroniser plus rise/fall detection, instantiated once per input.

Verification
REQ-036 Read 0x00, single byte (command 0x80) -> MISO returns 0xE5.
REQ-037 Write 0x31=0x0B (command 0x31, data 0x0B) -> one reg_wr pulse with addr 0x31, data 0x0B; data_format=0x0B.
REQ-038 sample x=0x1234, y=0xABCD, z=0x0F0F in IDLE, then multi-byte read of 6 bytes (command 0xF2) -> 34 12 CD AB 0F 0F.
REQ-039 sample_valid during byte 2 of a 6-byte read -> all 6 bytes come from the old sample; after CS rises, a re-read returns the new sample.
REQ-040 Write 0x32=0x55 -> no reg_wr pulse; a re-read of 0x32 is unchanged. MB read at 0x3F for 2 bytes -> returns reg[0x3F] then 0xE5.
REQ-041 CS raised after 4 command bits, then a fresh read of 0x2C -> 0x0A, FSM unaffected by the aborted command. rst while CS low -> no response until CS cycles.
